// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
//   INSTR_BYTES   : size of one instruction word in bytes
//   fetch_entry_t : prefetch buffer entry, an instruction word tagged with its PC
//   wrap_pc       : next sequential PC, wrapped into the instruction space
//   align_pc      : word-aligns an address and folds it into the instruction space
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic logic [31:0] wrap_pc(input logic [31:0] addr, input logic [31:0] mem_bytes);
    return (addr + INSTR_BYTES) % mem_bytes;
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] addr, input logic [31:0] mem_bytes);
    return {addr[31:2], 2'b00} % mem_bytes;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch stage's bus signals.
//   memory side : memory_address1 (out of fetch), memory_data1 (into fetch)
//   execute side: redirect_valid, redirect_pc (into fetch)
//   decode side : instr_valid, instr_data, instr_pc, fetch_fault (out of fetch),
//                 instr_ready (into fetch)
// modport master is the fetch stage, modport slave is the surrounding system.
interface fetch_if;

  logic [31:0] memory_address1;
  logic [31:0] memory_data1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_fault;

  modport master (
    output memory_address1, instr_valid, instr_data, instr_pc, fetch_fault,
    input  memory_data1, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  memory_address1, instr_valid, instr_data, instr_pc, fetch_fault,
    output memory_data1, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch FIFO of fetch_entry_t.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_entry at the tail (ignored when full unless popping)
//   pop        : retire the head entry (ignored when empty)
//   flush      : empty the FIFO; overrides push and pop
//   count      : number of valid entries (0..DEPTH)
//   head       : entry at the head, zero while empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count_reg != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && !flush && ((count_reg != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
      count_next = count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_entry;
  end

  assign count = count_reg;
  assign head  = (count_reg != '0) ? mem_reg[rd_ptr_reg] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC, issues word addresses on memory
// port 1, tags each returned word with its PC, buffers it in a prefetch FIFO
// and hands instructions to decode over valid/ready. Execute can redirect
// the PC; a misaligned target raises a sticky fault that blocks fetching
// until the next aligned redirect.
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : fetch_if.master (memory port 1, redirect, decode handshake, fault)
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_BYTES  = 64,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] MEM_SIZE = 32'(MEM_BYTES);

  logic [31:0]   pc_reg, pc_next;
  logic          inflight_reg, inflight_next;
  logic [31:0]   inflight_pc_reg, inflight_pc_next;
  logic          inflight_epoch_reg, inflight_epoch_next;
  logic          epoch_reg, epoch_next;
  logic          fault_reg, fault_next;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  head_entry;
  fetch_entry_t  push_entry;
  logic          pop, push, issue;
  logic [CW:0]   occupancy;

  assign pop = bus.instr_valid && bus.instr_ready;

  // A response is kept only if it belongs to the current epoch and no flush
  // is happening in the same cycle.
  assign push       = inflight_reg && (inflight_epoch_reg == epoch_reg) && !bus.redirect_valid;
  assign push_entry = '{pc: inflight_pc_reg, data: bus.memory_data1};

  // Reserve a slot for the response already in flight so the FIFO can never
  // overflow, while still allowing one issue per cycle when decode drains.
  assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(inflight_reg) - (CW+1)'(pop);
  assign issue     = !fault_reg && !bus.redirect_valid && (occupancy < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    pc_next             = pc_reg;
    inflight_next       = issue;
    inflight_pc_next    = pc_reg;
    inflight_epoch_next = epoch_reg;
    epoch_next          = epoch_reg;
    fault_next          = fault_reg;
    if (bus.redirect_valid) begin
      epoch_next = ~epoch_reg;
      pc_next    = align_pc(bus.redirect_pc, MEM_SIZE);
      fault_next = (bus.redirect_pc[1:0] != 2'b00);
    end else if (issue) begin
      pc_next = wrap_pc(pc_reg, MEM_SIZE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg             <= RESET_PC;
      inflight_reg       <= 1'b0;
      inflight_pc_reg    <= '0;
      inflight_epoch_reg <= 1'b0;
      epoch_reg          <= 1'b0;
      fault_reg          <= 1'b0;
    end else begin
      pc_reg             <= pc_next;
      inflight_reg       <= inflight_next;
      inflight_pc_reg    <= inflight_pc_next;
      inflight_epoch_reg <= inflight_epoch_next;
      epoch_reg          <= epoch_next;
      fault_reg          <= fault_next;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .count      (fifo_count),
    .head       (head_entry)
  );

  assign bus.memory_address1 = pc_reg;
  assign bus.instr_valid     = (fifo_count != '0);
  assign bus.instr_data      = head_entry.data;
  assign bus.instr_pc        = head_entry.pc;
  assign bus.fetch_fault     = fault_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch (RESET_PC=0, MEM_BYTES=64,
// FIFO_DEPTH=4). Memory word[i] = 32'hA000_0000 + i, read with one cycle of
// latency. Inputs are applied and outputs checked at the falling edge.
module tb_instruction_fetch;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  fetch_if bus ();

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .MEM_BYTES  (64),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];

  always @(posedge clk) bus.memory_data1 <= mem[bus.memory_address1[5:2]];

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [31];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance to the next falling edge.
  task automatic step(input string tag, input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                      input logic ef);
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    $display("%s rdy=%b rv=%b rpc=%h addr=%h valid=%b pc=%h data=%h fault=%b", tag, rdy, rv, rpc,
             bus.memory_address1, bus.instr_valid, bus.instr_pc, bus.instr_data, bus.fetch_fault);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'(ev));
    chk({tag, ".addr"}, bus.memory_address1, eaddr);
    chk({tag, ".fault"}, 32'(bus.fetch_fault), 32'(ef));
    if (ev) begin
      chk({tag, ".pc"}, bus.instr_pc, epc);
      chk({tag, ".data"}, bus.instr_data, 32'hA000_0000 + (epc >> 2));
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'h0);
    chk({tag, ".data"}, bus.instr_data, 32'h0);
    chk({tag, ".pc"}, bus.instr_pc, 32'h0);
    chk({tag, ".addr"}, bus.memory_address1, 32'h0);
    chk({tag, ".fault"}, 32'(bus.fetch_fault), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);

    // Cycle 0 is the first cycle after reset release. Decode stalls from the
    // first valid (cycle 2) through cycle 11, then streams across the wrap.
    for (int c = 0; c < 31; c++) begin
      if (c < 2)
        vecs[c] = '{1'b1, 1'b0, 32'h0, 32'(4 * c)};
      else if (c < 12)
        vecs[c] = '{1'b0, 1'b1, 32'h0, (c < 4) ? 32'(4 * c) : 32'd16};
      else
        vecs[c] = '{1'b1, 1'b1, 32'((4 * (c - 12)) % 64), 32'((16 + 4 * (c - 12)) % 64)};
    end

    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int c = 0; c < 31; c++)
      step($sformatf("c%0d", c), vecs[c].ready, 1'b0, 32'h0,
           vecs[c].exp_valid, vecs[c].exp_pc, vecs[c].exp_addr, 1'b0);

    // Aligned redirect to 0x20 while streaming.
    step("redir", 1'b1, 1'b1, 32'h20, 1'b1, 32'h0C, 32'h1C, 1'b0);
    step("redir+1", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h20, 1'b0);
    step("redir+2", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h24, 1'b0);
    step("redir+3", 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 32'h28, 1'b0);
    step("redir+4", 1'b1, 1'b0, 32'h0, 1'b1, 32'h24, 32'h2C, 1'b0);

    // Back-to-back redirects: 0x30 then 0x10; 0x30 data must never show.
    step("b2b", 1'b1, 1'b1, 32'h30, 1'b1, 32'h28, 32'h30, 1'b0);
    step("b2b+1", 1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 32'h30, 1'b0);
    step("b2b+2", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h10, 1'b0);
    step("b2b+3", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h14, 1'b0);
    step("b2b+4", 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 32'h18, 1'b0);
    step("b2b+5", 1'b1, 1'b0, 32'h0, 1'b1, 32'h14, 32'h1C, 1'b0);

    // Misaligned redirect blocks fetch until an aligned one arrives.
    step("mis", 1'b1, 1'b1, 32'h22, 1'b1, 32'h18, 32'h20, 1'b0);
    for (int i = 1; i <= 20; i++)
      step($sformatf("mis+%0d", i), 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h20, 1'b1);
    step("fix", 1'b1, 1'b1, 32'h08, 1'b0, 32'h0, 32'h20, 1'b1);
    step("fix+1", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h08, 1'b0);
    step("fix+2", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0C, 1'b0);
    step("fix+3", 1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 32'h10, 1'b0);
    step("fix+4", 1'b1, 1'b0, 32'h0, 1'b1, 32'h0C, 32'h14, 1'b0);

    // Fill the FIFO to 3 entries with decode stalled, then pulse reset mid-cycle.
    step("fill", 1'b0, 1'b1, 32'h00, 1'b1, 32'h10, 32'h18, 1'b0);
    step("fill+1", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h00, 1'b0);
    step("fill+2", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h04, 1'b0);
    step("fill+3", 1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 32'h08, 1'b0);
    step("fill+4", 1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 32'h0C, 1'b0);
    #1;
    chk("prerst.valid", 32'(bus.instr_valid), 32'h1);
    chk("prerst.addr", bus.memory_address1, 32'h10);
    #1 reset = 1'b0;
    #1;
    $display("async_reset addr=%h valid=%b pc=%h data=%h fault=%b", bus.memory_address1,
             bus.instr_valid, bus.instr_pc, bus.instr_data, bus.fetch_fault);
    chk_zero("arst");
    #1 reset = 1'b1;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    step("rst+1", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h04, 1'b0);
    step("rst+2", 1'b1, 1'b0, 32'h0, 1'b1, 32'h00, 32'h08, 1'b0);
    step("rst+3", 1'b1, 1'b0, 32'h0, 1'b1, 32'h04, 32'h0C, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
